disaster_alarm_sequencer: RTL and testbench
===========================================

Name: disaster_alarm_sequencer

Overview:
- Downstream stage of the combinational disaster classifier.
- Consumes the four raw hazard flags (flood, cyclone, earthquake, tsunami) and debounces them over periodic sample ticks into confirmed hazards.
- Sequences an operator alarm: siren, blinking danger LED, acknowledge, and timed recovery back to safe.
- Drives the front-panel alarm outputs and keeps a saturating event counter.

Parameters:
- CONFIRM_TICKS, 3: consecutive asserted samples required to confirm a hazard (1..15).
- CLEAR_TICKS, 4: consecutive deasserted samples required to clear a confirmed hazard (1..15).
- HOLD_TICKS, 8: ticks spent in RECOVERY before returning to SAFE (1..255).
- BLINK_TICKS, 2: ticks per danger-LED half-period in ALARM (1..255).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-cycle strobe; raw flags are sampled and all tick-based counters advance only on cycles where it is high.
- hazard_raw  input  4  raw flags: [0] flood, [1] cyclone, [2] earthquake, [3] tsunami.
- ack  input  1  operator acknowledge, level-sampled each cycle.
- confirmed  output  4  debounced hazards, same bit order as hazard_raw.
- state  output  3  FSM state encoding: SAFE=0, WATCH=1, ALARM=2, ACKED=3, RECOVERY=4.
- siren  output  1  high only in ALARM.
- danger_led  output  1  blinking in ALARM, steady 1 in ACKED, 0 otherwise.
- safe_led  output  1  high only in SAFE.
- top_code  output  2  highest-priority confirmed hazard: 3 tsunami, 2 earthquake, 1 cyclone, 0 flood.
- top_valid  output  1  confirmed != 0.
- event_count  output  8  number of new-confirmation events; saturates at 255.

Behaviour:
- Reset is synchronous, active-high, one clock. It overrides tick and ack in the same cycle.
- Reset values:
  - state=SAFE; confirmed=0; siren=0; danger_led=0; safe_led=1.
  - top_code=0; top_valid=0; event_count=0.
  - Blink phase=1; all counters=0; sampled-raw register=0.
- Debounce, per bit, on a tick only:
  - If raw equals confirmed, the counter clears to 0.
  - Otherwise the counter increments. When the incremented value reaches the threshold (CONFIRM_TICKS if raw=1, CLEAR_TICKS if raw=0), confirmed toggles and the counter clears.
  - A threshold of 1 means confirmed changes on the first differing tick.
  - Non-tick cycles hold all debounce state.
- Confirmed latency: confirmed rises on the clock edge of the CONFIRM_TICKS-th consecutive asserted tick.
- The FSM reads the registered confirmed value, so state changes one cycle after confirmed changes.
- New event: any bit of confirmed & ~confirmed_prev, counted once per cycle even if several bits rise together. event_count increments by 1 and saturates at 255.
- The last raw sample (raw_seen = |hazard_raw latched on tick) is held in a register.
- FSM transitions:
  - SAFE: raw_seen=1 -> WATCH.
  - WATCH: confirmed!=0 -> ALARM; else raw_seen=0 -> SAFE.
  - ALARM: confirmed=0 -> RECOVERY; else ack=1 -> ACKED. confirmed=0 takes precedence over ack.
  - ACKED: new event -> ALARM; else confirmed=0 -> RECOVERY.
  - RECOVERY: confirmed!=0 -> ALARM. Otherwise the hold counter counts ticks, and the HOLD_TICKS-th tick -> SAFE.
  - The hold counter clears on entry to RECOVERY.
- Blink:
  - On entering ALARM: blink phase=1 and blink counter=0.
  - Each tick in ALARM increments the counter; reaching BLINK_TICKS toggles the phase and clears the counter.
  - danger_led = phase while in ALARM.
- ack in any state other than ALARM is ignored. ack held high across re-entry to ALARM acknowledges on the next cycle.
- top_code and top_valid are registered from the next-cycle confirmed value, i.e. aligned with confirmed. Priority is tsunami > earthquake > cyclone > flood.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package disaster_pkg:
  - State enum and encodings.
  - Hazard bit indices (HZ_FLOOD=0, HZ_CYCLONE=1, HZ_QUAKE=2, HZ_TSUNAMI=3).
  - Priority codes.
- Sub-module hazard_debouncer:
  - Parameters CONFIRM_TICKS and CLEAR_TICKS; ports clk, rst, tick, raw, confirmed.
  - Instantiated 4x.
- FSM, blink, hold and event logic live in the top module.

Test Plan:
- Reset, then hazard_raw=4'b0100 held, tick every 4 cycles -> WATCH after 1st tick; confirmed[2]=1 at 3rd tick; next cycle state=ALARM, siren=1, top_code=2, event_count=1.
- In ALARM, ack pulse -> ACKED, siren=0, danger_led steady 1. Then hazard_raw |= 4'b1000 for 3 ticks -> ALARM again, top_code=3, event_count=2.
- Flag raised for 2 ticks then dropped (glitch shorter than CONFIRM_TICKS) -> confirmed stays 0, WATCH then SAFE, event_count=0.
- Clear all raw inputs from ACKED -> confirmed=0 after 4 ticks, RECOVERY. Re-raise during hold -> ALARM. Otherwise SAFE after 8 ticks with safe_led=1.
- In ALARM with BLINK_TICKS=2 -> danger_led pattern 1,1,0,0,1 across successive ticks. Assert rst mid-blink -> all outputs at reset values the next cycle.
- Confirm 256 distinct events by toggling flood -> event_count saturates at 255. Also: ack and confirmed→0 in the same cycle -> RECOVERY.

Source files
------------

// File: rtl/disaster_pkg.sv
// Shared definitions for the disaster alarm sequencer.
//   state_t      : FSM state encodings (also the value driven on the state port)
//   HZ_*         : bit positions of each hazard in the 4-bit hazard vectors
//   CODE_*       : priority codes reported on top_code
//   top_code_of  : highest-priority hazard in a 4-bit hazard vector
package disaster_pkg;

  typedef enum logic [2:0] {
    ST_SAFE     = 3'd0,
    ST_WATCH    = 3'd1,
    ST_ALARM    = 3'd2,
    ST_ACKED    = 3'd3,
    ST_RECOVERY = 3'd4
  } state_t;

  localparam int HZ_FLOOD   = 0;
  localparam int HZ_CYCLONE = 1;
  localparam int HZ_QUAKE   = 2;
  localparam int HZ_TSUNAMI = 3;

  localparam logic [1:0] CODE_FLOOD   = 2'd0;
  localparam logic [1:0] CODE_CYCLONE = 2'd1;
  localparam logic [1:0] CODE_QUAKE   = 2'd2;
  localparam logic [1:0] CODE_TSUNAMI = 2'd3;

  // Priority: tsunami > earthquake > cyclone > flood. An empty vector
  // reports the flood code; top_valid qualifies it.
  function automatic logic [1:0] top_code_of(input logic [3:0] hz);
    if (hz[HZ_TSUNAMI])      return CODE_TSUNAMI;
    else if (hz[HZ_QUAKE])   return CODE_QUAKE;
    else if (hz[HZ_CYCLONE]) return CODE_CYCLONE;
    else                     return CODE_FLOOD;
  endfunction

endpackage

// File: rtl/hazard_debouncer.sv
// Single-bit tick-based debouncer.
//   clk, rst  : clock, synchronous active-high reset
//   tick      : sample strobe; state only advances when high
//   raw       : raw hazard flag
//   confirmed : debounced flag (registered)
// A run of CONFIRM_TICKS differing samples with raw=1 sets confirmed, a run
// of CLEAR_TICKS differing samples with raw=0 clears it. Any sample that
// agrees with confirmed restarts the run.
module hazard_debouncer #(
  parameter int CONFIRM_TICKS = 3,
  parameter int CLEAR_TICKS   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic confirmed
);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic [3:0] thr;
  logic       conf_q, conf_d;

  always_comb begin
    cnt_d   = cnt_q;
    conf_d  = conf_q;
    cnt_inc = cnt_q + 4'd1;
    thr     = raw ? 4'(CONFIRM_TICKS) : 4'(CLEAR_TICKS);
    if (tick) begin
      if (raw == conf_q) begin
        cnt_d = 4'd0;
      end else if (cnt_inc == thr) begin
        conf_d = ~conf_q;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      conf_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      conf_q <= conf_d;
    end
  end

  assign confirmed = conf_q;

endmodule

// File: rtl/disaster_alarm_sequencer.sv
// Debounces four raw hazard flags and sequences the operator alarm.
//   clk, rst    : clock, synchronous active-high reset
//   sample_tick : sample strobe for debounce, hold and blink counters
//   hazard_raw  : raw flags [0]flood [1]cyclone [2]earthquake [3]tsunami
//   ack         : operator acknowledge (level, only honoured in ALARM)
//   confirmed   : debounced hazards
//   state       : FSM state (SAFE/WATCH/ALARM/ACKED/RECOVERY = 0..4)
//   siren       : high in ALARM
//   danger_led  : blinks in ALARM, steady in ACKED
//   safe_led    : high in SAFE
//   top_code    : highest-priority confirmed hazard
//   top_valid   : any hazard confirmed
//   event_count : saturating count of new-confirmation events
module disaster_alarm_sequencer
  import disaster_pkg::*;
#(
  parameter int CONFIRM_TICKS = 3,
  parameter int CLEAR_TICKS   = 4,
  parameter int HOLD_TICKS    = 8,
  parameter int BLINK_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic [3:0] hazard_raw,
  input  logic       ack,
  output logic [3:0] confirmed,
  output logic [2:0] state,
  output logic       siren,
  output logic       danger_led,
  output logic       safe_led,
  output logic [1:0] top_code,
  output logic       top_valid,
  output logic [7:0] event_count
);

  logic [3:0] conf;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    hazard_debouncer #(
      .CONFIRM_TICKS(CONFIRM_TICKS),
      .CLEAR_TICKS  (CLEAR_TICKS)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .tick     (sample_tick),
      .raw      (hazard_raw[i]),
      .confirmed(conf[i])
    );
  end

  state_t     state_q, state_d;
  logic [3:0] conf_prev_q;
  logic       raw_seen_q, raw_seen_d;
  logic [7:0] hold_q, hold_d, hold_inc;
  logic [7:0] blink_q, blink_d, blink_inc;
  logic       phase_q, phase_d;
  logic [7:0] evt_q, evt_d;
  logic       siren_q, siren_d;
  logic       danger_q, danger_d;
  logic       safe_q, safe_d;
  logic       new_event;
  logic       any_conf;

  assign any_conf  = |conf;
  // Counted once per cycle no matter how many bits rise together.
  assign new_event = |(conf & ~conf_prev_q);
  assign hold_inc  = hold_q + 8'd1;
  assign blink_inc = blink_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    raw_seen_d = sample_tick ? |hazard_raw : raw_seen_q;
    hold_d     = hold_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    evt_d      = (new_event && evt_q != 8'hFF) ? evt_q + 8'd1 : evt_q;

    case (state_q)
      ST_SAFE:  if (raw_seen_q) state_d = ST_WATCH;
      ST_WATCH: begin
        if (any_conf)         state_d = ST_ALARM;
        else if (!raw_seen_q) state_d = ST_SAFE;
      end
      ST_ALARM: begin
        // Losing every hazard wins over a simultaneous acknowledge.
        if (!any_conf) state_d = ST_RECOVERY;
        else if (ack)  state_d = ST_ACKED;
        if (sample_tick) begin
          if (blink_inc == 8'(BLINK_TICKS)) begin
            phase_d = ~phase_q;
            blink_d = 8'd0;
          end else begin
            blink_d = blink_inc;
          end
        end
      end
      ST_ACKED: begin
        if (new_event)      state_d = ST_ALARM;
        else if (!any_conf) state_d = ST_RECOVERY;
      end
      ST_RECOVERY: begin
        if (any_conf) begin
          state_d = ST_ALARM;
        end else if (sample_tick) begin
          if (hold_inc == 8'(HOLD_TICKS)) state_d = ST_SAFE;
          hold_d = hold_inc;
        end
      end
      default: state_d = ST_SAFE;
    endcase

    if (state_d == ST_RECOVERY && state_q != ST_RECOVERY) hold_d = 8'd0;
    if (state_d == ST_ALARM && state_q != ST_ALARM) begin
      phase_d = 1'b1;
      blink_d = 8'd0;
    end

    // Outputs follow the next state so they are registered alongside it.
    siren_d  = (state_d == ST_ALARM);
    safe_d   = (state_d == ST_SAFE);
    danger_d = (state_d == ST_ALARM) ? phase_d : (state_d == ST_ACKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SAFE;
      conf_prev_q <= 4'd0;
      raw_seen_q  <= 1'b0;
      hold_q      <= 8'd0;
      blink_q     <= 8'd0;
      phase_q     <= 1'b1;
      evt_q       <= 8'd0;
      siren_q     <= 1'b0;
      danger_q    <= 1'b0;
      safe_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      conf_prev_q <= conf;
      raw_seen_q  <= raw_seen_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      evt_q       <= evt_d;
      siren_q     <= siren_d;
      danger_q    <= danger_d;
      safe_q      <= safe_d;
    end
  end

  assign confirmed   = conf;
  assign state       = state_q;
  assign siren       = siren_q;
  assign danger_led  = danger_q;
  assign safe_led    = safe_q;
  // Decoded straight from the confirmed flops so it is aligned with confirmed.
  assign top_code    = top_code_of(conf);
  assign top_valid   = any_conf;
  assign event_count = evt_q;

endmodule

// File: tb/tb_disaster_alarm_sequencer.sv
// Directed bench for disaster_alarm_sequencer with default parameters
// (CONFIRM=3, CLEAR=4, HOLD=8, BLINK=2). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_disaster_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic [3:0] hazard_raw = 4'd0;
  logic       ack = 1'b0;
  logic [3:0] confirmed;
  logic [2:0] state;
  logic       siren, danger_led, safe_led, top_valid;
  logic [1:0] top_code;
  logic [7:0] event_count;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] S_SAFE = 3'd0, S_WATCH = 3'd1, S_ALARM = 3'd2,
                         S_ACKED = 3'd3, S_RECOV = 3'd4;

  disaster_alarm_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .hazard_raw (hazard_raw),
    .ack        (ack),
    .confirmed  (confirmed),
    .state      (state),
    .siren      (siren),
    .danger_led (danger_led),
    .safe_led   (safe_led),
    .top_code   (top_code),
    .top_valid  (top_valid),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One tick cycle; results of the tick are visible on return.
  task automatic tick1();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_state"},     8'(state), 8'(S_SAFE));
    check({pfx, "_confirmed"}, 8'(confirmed), 8'd0);
    check({pfx, "_siren"},     8'(siren), 8'd0);
    check({pfx, "_danger"},    8'(danger_led), 8'd0);
    check({pfx, "_safe_led"},  8'(safe_led), 8'd1);
    check({pfx, "_top_code"},  8'(top_code), 8'd0);
    check({pfx, "_top_valid"}, 8'(top_valid), 8'd0);
    check({pfx, "_events"},    event_count, 8'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    idle(2);
    check_reset("rst");
    rst = 1'b0;
    step();

    // Earthquake held, tick every 4 cycles
    hazard_raw = 4'b0100;
    tick1();
    check("t1_still_safe", 8'(state), 8'(S_SAFE));
    step();
    check("t1_watch", 8'(state), 8'(S_WATCH));
    idle(2);
    tick1(); idle(3);
    tick1();
    check("q_confirmed", 8'(confirmed), 8'h04);
    check("q_top_code", 8'(top_code), 8'd2);
    check("q_top_valid", 8'(top_valid), 8'd1);
    check("q_state_watch", 8'(state), 8'(S_WATCH));
    step();
    check("q_alarm", 8'(state), 8'(S_ALARM));
    check("q_siren", 8'(siren), 8'd1);
    check("q_events1", event_count, 8'd1);
    check("blink0", 8'(danger_led), 8'd1);
    idle(2);

    // Blink pattern 1,1,0,0,1 (entry value above, then per tick)
    tick1(); check("blink1", 8'(danger_led), 8'd1); idle(3);
    tick1(); check("blink2", 8'(danger_led), 8'd0); idle(3);
    tick1(); check("blink3", 8'(danger_led), 8'd0); idle(3);
    tick1(); check("blink4", 8'(danger_led), 8'd1); idle(3);

    // Acknowledge
    ack = 1'b1; step(); ack = 1'b0;
    check("ack_state", 8'(state), 8'(S_ACKED));
    check("ack_siren", 8'(siren), 8'd0);
    check("ack_danger", 8'(danger_led), 8'd1);

    // Tsunami added while acknowledged -> re-alarm
    hazard_raw = 4'b1100;
    tick1(); idle(3);
    tick1(); idle(3);
    tick1();
    check("ts_confirmed", 8'(confirmed), 8'h0C);
    check("ts_top_code", 8'(top_code), 8'd3);
    check("ts_state_acked", 8'(state), 8'(S_ACKED));
    step();
    check("ts_alarm", 8'(state), 8'(S_ALARM));
    check("ts_events2", event_count, 8'd2);

    // Acknowledge, then clear everything -> RECOVERY
    ack = 1'b1; step(); ack = 1'b0;
    check("ack2_state", 8'(state), 8'(S_ACKED));
    hazard_raw = 4'b0000;
    for (int i = 0; i < 3; i++) begin tick1(); idle(3); end
    tick1();
    check("clr_confirmed", 8'(confirmed), 8'h00);
    check("clr_top_valid", 8'(top_valid), 8'd0);
    step();
    check("clr_recovery", 8'(state), 8'(S_RECOV));
    check("clr_danger", 8'(danger_led), 8'd0);

    // Re-raise during hold -> ALARM
    hazard_raw = 4'b0001;
    tick1(); idle(3);
    tick1(); idle(3);
    tick1();
    check("rr_confirmed", 8'(confirmed), 8'h01);
    check("rr_top_code", 8'(top_code), 8'd0);
    step();
    check("rr_alarm", 8'(state), 8'(S_ALARM));
    check("rr_events3", event_count, 8'd3);

    // Drop flood; ack in same cycle the FSM sees confirmed=0 -> RECOVERY
    hazard_raw = 4'b0000;
    for (int i = 0; i < 3; i++) begin tick1(); idle(3); end
    tick1();
    check("drop_confirmed", 8'(confirmed), 8'h00);
    ack = 1'b1; step(); ack = 1'b0;
    check("ack_vs_clear", 8'(state), 8'(S_RECOV));

    // Hold for 8 ticks -> SAFE
    for (int i = 0; i < 7; i++) begin tick1(); idle(3); end
    check("hold7_recovery", 8'(state), 8'(S_RECOV));
    tick1();
    check("hold8_safe", 8'(state), 8'(S_SAFE));
    check("hold8_safe_led", 8'(safe_led), 8'd1);
    idle(3);

    // Cyclone -> ALARM, then reset mid-blink
    hazard_raw = 4'b0010;
    tick1(); idle(3);
    tick1(); idle(3);
    tick1();
    check("cy_top_code", 8'(top_code), 8'd1);
    step();
    check("cy_alarm", 8'(state), 8'(S_ALARM));
    check("cy_events4", event_count, 8'd4);
    idle(2);
    tick1(); check("cy_blink1", 8'(danger_led), 8'd1); idle(3);
    tick1(); check("cy_blink2", 8'(danger_led), 8'd0);
    rst = 1'b1;
    sample_tick = 1'b1;
    ack = 1'b1;
    step();
    check_reset("midrst");
    rst = 1'b0;
    sample_tick = 1'b0;
    ack = 1'b0;
    hazard_raw = 4'b0000;
    step();

    // Glitch of 2 ticks -> WATCH then SAFE, no confirmation
    hazard_raw = 4'b0001;
    tick1();
    step();
    check("gl_watch", 8'(state), 8'(S_WATCH));
    idle(2);
    tick1(); idle(3);
    check("gl_confirmed_mid", 8'(confirmed), 8'h00);
    hazard_raw = 4'b0000;
    tick1();
    check("gl_confirmed", 8'(confirmed), 8'h00);
    step();
    check("gl_safe", 8'(state), 8'(S_SAFE));
    check("gl_events0", event_count, 8'd0);

    // 255 flood events with a tick every cycle, then one more to saturate
    sample_tick = 1'b1;
    for (int e = 0; e < 255; e++) begin
      hazard_raw = 4'b0001; idle(3);
      hazard_raw = 4'b0000; idle(4);
    end
    sample_tick = 1'b0;
    step();
    check("sat_255", event_count, 8'd255);
    sample_tick = 1'b1;
    hazard_raw = 4'b0001; idle(3);
    hazard_raw = 4'b0000; idle(4);
    sample_tick = 1'b0;
    step();
    check("sat_256", event_count, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
